// File: rtl/mem_pkg.sv
// Shared definitions for the mem_master controller and the memory-side blocks:
// controller state encoding and default memory geometry.
package mem_pkg;

    // Default memory geometry, shared with the memory block and its benches
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 3;
    localparam int unsigned DEF_ADDR_LIMIT = 7;
    localparam int unsigned DEF_RD_LAT     = 1;

    // Width of the read-latency down-counter (MEM_RD_LAT is 1..4)
    localparam int unsigned LAT_W = 3;

    // Controller states; VRD is only reachable with MEM_MASTER_WR_VERIFY_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        VRD   = 3'd4,
        ERR   = 3'd5,
        RESP  = 3'd6
    } state_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address screen: an address is valid when it is below
// ADDR_LIMIT. Shared with memory-side checkers.
module mem_addr_check #(
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned ADDR_LIMIT = 7
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid
);

    // Compare in 32 bits so ADDR_LIMIT may equal 2**ADDR_W
    always_comb begin
        o_valid = (32'(i_addr) < ADDR_LIMIT);
    end

endmodule

// File: rtl/mem_master.sv
// Initiator-side controller for the memory block: accepts one read or write
// command at a time over valid/ready, sequences the memory strobes and
// returns one response per command. Out-of-range addresses are answered
// with an error and never reach the memory.
// Optional feature macro: MEM_MASTER_WR_VERIFY_EN (read back each write and
// flag a mismatch on rsp_err).
module mem_master
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned ADDR_LIMIT = DEF_ADDR_LIMIT,
    parameter int unsigned MEM_RD_LAT = DEF_RD_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr_w,
    output logic [ADDR_W-1:0] mem_addr_r,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_RD_LAT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_addr_ok;
    logic               w_hs;
    logic               w_cmd_ready;
    logic               w_rsp_valid;
    logic               w_mem_write;
    logic               w_mem_read;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic               r_verify;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic [ADDR_W-1:0]  r_mem_addr_w;
    logic [ADDR_W-1:0]  r_mem_addr_r;
    logic [DATA_W-1:0]  r_mem_datain;

    mem_addr_check #(
        .ADDR_W     (ADDR_W),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_addr_check (
        .i_addr  (cmd_addr),
        .o_valid (w_addr_ok)
    );

    assign w_hs = cmd_valid & w_cmd_ready;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and strobe/handshake outputs
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = ~reset;
                if (cmd_valid && !reset) begin
                    if (!w_addr_ok) begin
                        w_next = ERR;
                    end else if (cmd_write) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            WR: begin
                w_mem_write = 1'b1;
`ifdef MEM_MASTER_WR_VERIFY_EN
                w_next = VRD;
`else
                w_next = RESP;
`endif
            end
            RD: begin
                w_mem_read = 1'b1;
                w_next     = RWAIT;
            end
            VRD: begin
`ifdef MEM_MASTER_WR_VERIFY_EN
                w_mem_read = 1'b1;
                w_next     = RWAIT;
`else
                w_next = IDLE;
`endif
            end
            RWAIT: begin
                if (r_lat_cnt == '0) begin
                    w_next = RESP;
                end
            end
            ERR: begin
                w_next = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Command capture, memory address/data registers, latency count, response
    // The memory-side address/data registers double as the captured command
    // fields, so the write-verify compare uses mem_addr_w/mem_datain directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lat_cnt    <= '0;
            r_verify     <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_mem_addr_w <= '0;
            r_mem_addr_r <= '0;
            r_mem_datain <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_verify    <= 1'b0;
                        if (w_addr_ok) begin
                            if (cmd_write) begin
                                r_mem_addr_w <= cmd_addr;
                                r_mem_datain <= cmd_wdata;
                            end else begin
                                r_mem_addr_r <= cmd_addr;
                            end
                        end
                    end
                end
                WR: begin
`ifdef MEM_MASTER_WR_VERIFY_EN
                    r_mem_addr_r <= r_mem_addr_w;
                    r_verify     <= 1'b1;
`endif
                end
                RD, VRD: begin
                    r_lat_cnt <= LAT_INIT;
                end
                RWAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_rsp_rdata <= mem_dataout;
                        if (r_verify) begin
                            r_rsp_err <= (mem_dataout != r_mem_datain);
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                ERR: begin
                    r_rsp_err   <= 1'b1;
                    r_rsp_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign rsp_valid  = w_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign mem_write  = w_mem_write;
    assign mem_read   = w_mem_read;
    assign mem_addr_w = r_mem_addr_w;
    assign mem_addr_r = r_mem_addr_r;
    assign mem_datain = r_mem_datain;

endmodule
